// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame from a single-clock FIFO
// and sends it as start bit, DATA_WIDTH data bits LSB first, then stop bit(s).
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_do_i,
    output logic                  fifo_remove_o,
    output logic                  txd_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int unsigned BaudW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitMax = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int unsigned BitW   = (BitMax > 1) ? $clog2(BitMax) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DATA_WIDTH - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                  state_q, state_d;
    logic [BaudW-1:0]        baud_q, baud_d;
    logic [BitW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    txd_q, txd_d;
    logic                    fifo_remove_q, fifo_remove_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    logic baud_last;
    logic can_start;

    assign baud_last = (baud_q == BaudLast);
    assign can_start = enable_i && !fifo_empty_i;

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        unique case (state_q)
            StIdle: begin
                if (can_start) state_d = StFetch;
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                // fifo_do is valid now, one cycle after the pop was sampled
                shift_d = fifo_do_i;
                baud_d  = '0;
                bit_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        bit_d   = '0;
                        state_d = can_start ? StFetch : StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        txd_d = 1'b1;
        if (state_d == StStart) begin
            txd_d = 1'b0;
        end else if (state_d == StData) begin
            txd_d = shift_d[0];
        end
        fifo_remove_d = (state_d == StFetch);
        busy_d        = (state_d != StIdle);
        frame_done_d  = (state_d == StStop) && (baud_d == BaudLast) && (bit_d == StopLast);
    end

    // State, counters, shifter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            baud_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            txd_q         <= 1'b1;
            fifo_remove_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            txd_q         <= txd_d;
            fifo_remove_q <= fifo_remove_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign txd_o         = txd_q;
    assign fifo_remove_o = fifo_remove_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO environment plus a frame-level
// reference model that predicts txd/remove/busy/frame_done for every cycle.
module tb_fifo_uart_tx;

    localparam int DW  = 4;
    localparam int CPB = 4;
    localparam int SB  = 1;

    logic          clk     = 1'b0;
    logic          clk_en  = 1'b1;
    logic          rst_n   = 1'b0;
    logic          enable  = 1'b0;
    logic [DW-1:0] fifo_do = '0;
    logic          fifo_empty;
    logic          fifo_remove;
    logic          txd;
    logic          busy;
    logic          frame_done;

    // Second instance with non-default parameters
    logic       en1    = 1'b0;
    logic       empty1 = 1'b1;
    logic [7:0] do1    = 8'h00;
    logic       rem1;
    logic       txd1;
    logic       busy1;
    logic       fd1;

    // FIFO environment storage
    logic [DW-1:0] mem [0:1023];
    logic [9:0]    wr_ptr = '0;
    logic [9:0]    rd_ptr = '0;
    logic [9:0]    p0;
    logic          pop_empty_seen = 1'b0;

    // Reference model: words it still expects to send, and per-cycle expectations
    logic [DW-1:0] mdl_q [$];
    logic [3:0]    exp_q [$];
    logic [3:0]    cur_exp = 4'b1000;  // {txd, remove, busy, frame_done}

    int n_checks = 0;
    int n_fail   = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 if (clk_en) clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .fifo_empty_i (fifo_empty),
        .fifo_do_i    (fifo_do),
        .fifo_remove_o(fifo_remove),
        .txd_o        (txd),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    fifo_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(3),
        .STOP_BITS   (2)
    ) u_dut_p2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (en1),
        .fifo_empty_i (empty1),
        .fifo_do_i    (do1),
        .fifo_remove_o(rem1),
        .txd_o        (txd1),
        .busy_o       (busy1),
        .frame_done_o (fd1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 10'd1;
        mdl_q.push_back(w);
    endtask

    // Whole-frame expectation: fetch, load, start, data LSB first, stop(s)
    function automatic void build_frame(input logic [DW-1:0] w);
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b1010);
        for (int i = 0; i < CPB; i++) exp_q.push_back(4'b0010);
        for (int b = 0; b < DW; b++)
            for (int i = 0; i < CPB; i++) exp_q.push_back({w[b], 3'b010});
        for (int i = 0; i < SB * CPB; i++)
            exp_q.push_back((i == SB * CPB - 1) ? 4'b1011 : 4'b1010);
    endfunction

    // Expected {txd, remove, busy, frame_done} of the 8-bit/3-clk/2-stop instance
    function automatic logic [3:0] exp_p2(input int k);
        logic [7:0] w;
        w = 8'h81;
        if (k == 0) return 4'b1110;
        if (k == 1) return 4'b1010;
        if (k < 5) return 4'b0010;
        if (k < 29) return {w[(k - 5) / 3], 3'b010};
        if (k < 34) return 4'b1010;
        if (k == 34) return 4'b1011;
        return 4'b1000;
    endfunction

    // Model: when no frame is pending, decide at this edge whether one starts
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_exp <= 4'b1000;
        end else begin
            if (exp_q.size() == 0) begin
                if (enable && mdl_q.size() != 0) build_frame(mdl_q.pop_front());
                else exp_q.push_back(4'b1000);
            end
            cur_exp <= exp_q.pop_front();
        end
    end

    // FIFO read side: data appears the cycle after remove is sampled
    always @(posedge clk) begin
        if (rst_n && fifo_remove) begin
            if (fifo_empty) begin
                pop_empty_seen <= 1'b1;
            end else begin
                fifo_do <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 10'd1;
            end
        end
    end

    always @(negedge clk) begin
        check("cycle", 32'({txd, fifo_remove, busy, frame_done}), 32'(cur_exp));
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_remove", 32'(fifo_remove), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Reset mid-DATA with the clock stopped, then idle with an empty FIFO
        push(DW'($urandom));
        repeat (12) @(negedge clk);
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t1_txd", 32'(txd), 32'd1);
        check("t1_remove", 32'(fifo_remove), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        #10 rst_n = 1'b1;
        #2 clk_en = 1'b1;
        p0 = rd_ptr;
        repeat (100) @(negedge clk);
        check("t1_no_pop", 32'(rd_ptr - p0), 32'd0);
        check("t1_idle_txd", 32'(txd), 32'd1);

        // Single word
        p0 = rd_ptr;
        push(4'hA);
        repeat (30) @(negedge clk);
        check("t2_pops", 32'(rd_ptr - p0), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);

        // Back-to-back
        p0 = rd_ptr;
        push(4'h3);
        push(4'hC);
        repeat (60) @(negedge clk);
        check("t3_pops", 32'(rd_ptr - p0), 32'd2);

        // Enable drop mid-frame with words queued
        p0 = rd_ptr;
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_pops_held", 32'(rd_ptr - p0), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        repeat (70) @(negedge clk);
        check("t4_pops_all", 32'(rd_ptr - p0), 32'd3);

        // Reset during START, then a fresh frame
        push(DW'($urandom));
        for (int i = 0; i < 20 && txd !== 1'b0; i++) @(negedge clk);
        check("t5_start", 32'(txd), 32'd0);
        #2 rst_n = 1'b0;
        #1 check("t5_rst_txd", 32'(txd), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        p0 = rd_ptr;
        push(DW'($urandom));
        repeat (40) @(negedge clk);
        check("t5_pops", 32'(rd_ptr - p0), 32'd1);

        // Randomised traffic with enable toggling
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) push(DW'($urandom));
            if ($urandom_range(0, 99) == 0) enable = ~enable;
        end
        enable = 1'b1;
        for (int i = 0; i < 4000 && !(fifo_empty && !busy); i++) @(negedge clk);
        check("drain", 32'({fifo_empty, busy}), 32'd2);
        check("pop_on_empty", 32'(pop_empty_seen), 32'd0);

        // Parameter variant: 8 bits, 3 clks/bit, 2 stop bits, word 8'h81
        @(negedge clk);
        empty1 = 1'b0;
        en1    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rem1) begin
                empty1 = 1'b1;
                do1    = 8'h81;
                en1    = 1'b0;
            end
            check("p2_cycle", 32'({txd1, rem1, busy1, fd1}), 32'(exp_p2(k)));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
